pool1: RTL and testbench
========================

Name: pool1

Overview:
- 2x2, stride-2 max-pooling stage directly downstream of the first convolution stage.
- Consumes the ReLU'd 6-channel convolution stream: 24x24 valid pixels per frame, raster order, one beat per valid cycle.
- Produces a 12x12x6 raster stream for the next convolution stage.
- Uses one half-width line buffer per channel plus a horizontal pair register; no backpressure.

Parameters:
- CH, 6, number of channels packed in the data bus.
- DW, 32, bits per channel.
- IN_W, 24, input frame width in valid beats. Must be even.
- IN_H, 24, input frame height in rows. Must be even.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous assert, active low.
- cnn_data_in  input  CH*DW  channel c at bits [c*DW +: DW]; values non-negative (sign bit 0), compared unsigned.
- cnn_data_in_valid  input  1  qualifies cnn_data_in; one pixel per high cycle; gaps allowed anywhere.
- cnn_data_out  output  CH*DW  pooled pixel; same channel packing as input.
- cnn_data_out_valid  output  1  one-cycle pulse per pooled pixel.
- cnn_frame_last  output  1  high together with cnn_data_out_valid on the final (IN_W/2*IN_H/2-th) output of a frame.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: col_cnt=0, row_cnt=0, h_reg=0, cnn_data_out=0, cnn_data_out_valid=0, cnn_frame_last=0. Line buffer is not reset; it is always written before it is read.
- Counters:
  - col_cnt (0..IN_W-1) and row_cnt (0..IN_H-1) advance only on valid beats.
  - col wraps to 0 after IN_W-1 and increments row.
  - row wraps to 0 after the (IN_H-1, IN_W-1) beat; the next beat starts a new frame with no idle cycle required.
- Datapath per valid beat, all CH channels in parallel, unsigned compare:
  - col even: h_reg <= in.
  - col odd: hmax = max(h_reg, in), combinational.
  - col odd, row even: lbuf[col>>1] <= hmax. Depth IN_W/2, width CH*DW.
  - col odd, row odd: cnn_data_out <= max(lbuf[col>>1], hmax); cnn_data_out_valid <= 1.
  - cnn_frame_last <= 1 when row=IN_H-1 and col=IN_W-1.
- Latency: output registered exactly 1 clk after the accepted input beat at (odd row, odd col).
- Output valid is never asserted at any other time.
- cnn_data_out holds its last value while valid is low.
- Ties: equal operands give that value; no ordering ambiguity.
- Input gaps: all state (counters, h_reg, lbuf) holds; no output is produced.
- Reset mid-frame: counters return to 0. The next valid beat is treated as pixel (0,0) of a new frame. Partial-frame data is discarded and stale lbuf is overwritten before use.
- Width: no growth; output per channel is DW bits, identical to one of the inputs.
- Throughput: sustains 1 input beat/cycle; output rate is at most 1 per 2 cycles within odd rows.

Test Plan:
- Single frame, all channels ch c pixel(r,x)=r*24+x+c -> 144 outputs; out(i,j) ch c = (2i+1)*24+(2j+1)+c; first output pixel (0,0) ch0=25, last ch0=575 with cnn_frame_last=1 only on it.
- Max position sweep: for each 2x2 block, value 1000 placed at TL/TR/BL/BR in rotation, rest 5 -> every output = 1000; valid pulses exactly 1 cycle after each (odd,odd) beat.
- Random valid gaps (~40% low) on the ramp frame -> output values identical to the gap-free run; valid count 144; no output during gaps.
- Two frames back-to-back, second frame = first+10000 -> 288 outputs; frame 2 values offset by exactly 10000 (no line-buffer bleed); two cnn_frame_last pulses.
- Reset asserted at row 7, col 13 then a full frame -> outputs zero/low during reset; post-reset frame pooled correctly from pixel (0,0); 144 outputs.
- Channel isolation and unsigned compare: ch3 = 0x7FFFFFFF at one pixel per block, other channels 0 -> ch3 out 0x7FFFFFFF, all others 0.

Source files
------------

// File: rtl/pool1.sv
// 2x2 stride-2 max-pooling stage for the packed multi-channel convolution stream.
// Horizontal pairs meet in h_q; even-row pair maxima wait in a half-width line buffer.
module pool1 #(
    parameter int CH   = 6,
    parameter int DW   = 32,
    parameter int IN_W = 24,
    parameter int IN_H = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*DW-1:0]  cnn_data_in,
    input  logic              cnn_data_in_valid,
    output logic [CH*DW-1:0]  cnn_data_out,
    output logic              cnn_data_out_valid,
    output logic              cnn_frame_last
);

    localparam int BW = CH * DW;
    localparam int CW = $clog2(IN_W);
    localparam int RW = $clog2(IN_H);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic [BW-1:0] h_q;
    logic [BW-1:0] out_q;
    logic          valid_q;
    logic          last_q;
    logic [BW-1:0] lbuf [IN_W/2];
    logic [BW-1:0] lbuf_rd;
    logic [BW-1:0] hmax;
    logic [BW-1:0] vmax;
    logic          col_end;
    logic          row_end;

    assign col_end = (col_q == CW'(IN_W - 1));
    assign row_end = (row_q == RW'(IN_H - 1));
    assign lbuf_rd = lbuf[col_q[CW-1:1]];

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (cnn_data_in_valid) begin
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    // Per-channel unsigned max; ties pick either operand, which are equal anyway.
    always_comb begin
        hmax = '0;
        vmax = '0;
        for (int c = 0; c < CH; c++) begin
            hmax[c*DW +: DW] = (h_q[c*DW +: DW] >= cnn_data_in[c*DW +: DW]) ?
                               h_q[c*DW +: DW] : cnn_data_in[c*DW +: DW];
            vmax[c*DW +: DW] = (lbuf_rd[c*DW +: DW] >= hmax[c*DW +: DW]) ?
                               lbuf_rd[c*DW +: DW] : hmax[c*DW +: DW];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q   <= '0;
            row_q   <= '0;
            h_q     <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            col_q   <= col_d;
            row_q   <= row_d;
            if (cnn_data_in_valid) begin
                if (!col_q[0]) begin
                    h_q <= cnn_data_in;
                end else if (row_q[0]) begin
                    out_q   <= vmax;
                    valid_q <= 1'b1;
                    last_q  <= row_end && col_end;
                end
            end
        end
    end

    // Not reset: every entry is written on an even row before the odd row reads it.
    always_ff @(posedge clk) begin
        if (cnn_data_in_valid && col_q[0] && !row_q[0]) begin
            lbuf[col_q[CW-1:1]] <= hmax;
        end
    end

    assign cnn_data_out       = out_q;
    assign cnn_data_out_valid = valid_q;
    assign cnn_frame_last     = last_q;

endmodule

// File: tb/tb_pool1.sv
// Directed bench for pool1: ramp, max-position sweep, gaps, back-to-back frames,
// mid-frame reset and channel isolation, each with hand-derived expected outputs.
module tb_pool1;

    localparam int CH = 6;
    localparam int DW = 32;
    localparam int BW = CH * DW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [BW-1:0] din;
    logic          din_valid;
    logic [BW-1:0] dout;
    logic          dout_valid;
    logic          frame_last;

    int checks   = 0;
    int failures = 0;
    logic [BW-1:0] last_exp;
    int n_out;
    int n_last;

    pool1 #(.CH(CH), .DW(DW), .IN_W(24), .IN_H(24)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .cnn_data_in        (din),
        .cnn_data_in_valid  (din_valid),
        .cnn_data_out       (dout),
        .cnn_data_out_valid (dout_valid),
        .cnn_frame_last     (frame_last)
    );

    always #5 clk = ~clk;

    // kind: 0 ramp, 1 max sweep, 2 ramp+10000, 3 ch3 isolation
    function automatic logic [DW-1:0] pix_val(int kind, int r, int x, int c);
        int b, pos;
        b   = (r / 2) * 12 + (x / 2);
        pos = (r % 2) * 2 + (x % 2);
        case (kind)
            0: return 32'(r * 24 + x + c);
            1: return (pos == b % 4) ? 32'd1000 : 32'd5;
            2: return 32'(r * 24 + x + c + 10000);
            default: begin
                if (c == 3) return (pos == b % 4) ? 32'h7FFF_FFFF : 32'(pos + 1);
                return 32'd0;
            end
        endcase
    endfunction

    function automatic logic [DW-1:0] exp_val(int kind, int i, int j, int c);
        case (kind)
            0: return 32'((2 * i + 1) * 24 + (2 * j + 1) + c);
            1: return 32'd1000;
            2: return 32'((2 * i + 1) * 24 + (2 * j + 1) + c + 10000);
            default: return (c == 3) ? 32'h7FFF_FFFF : 32'd0;
        endcase
    endfunction

    function automatic logic [BW-1:0] pix_bus(int kind, int r, int x);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = pix_val(kind, r, x, c);
        return v;
    endfunction

    function automatic logic [BW-1:0] exp_bus(int kind, int i, int j);
        logic [BW-1:0] v;
        v = '0;
        for (int c = 0; c < CH; c++) v[c*DW +: DW] = exp_val(kind, i, j, c);
        return v;
    endfunction

    task automatic check_cycle(string tag, logic [BW+1:0] expv, int r, int x);
        checks++;
        assert ({dout_valid, frame_last, dout} === expv) else begin
            failures++;
            $error("FAIL %s r=%0d x=%0d got v=%0b l=%0b d=%h exp v=%0b l=%0b d=%h",
                   tag, r, x, dout_valid, frame_last, dout,
                   expv[BW+1], expv[BW], expv[BW-1:0]);
        end
    endtask

    task automatic idle_cycle(string tag);
        @(negedge clk);
        din_valid = 1'b0;
        din       = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        @(posedge clk);
        #1;
        check_cycle(tag, {1'b0, 1'b0, last_exp}, -1, -1);
    endtask

    // Sends up to max_beats beats of a frame, checking the output cycle after each beat.
    task automatic send_frame(string tag, int kind, int gap_pct, int max_beats);
        int beats;
        logic out_exp;
        beats  = 0;
        n_out  = 0;
        n_last = 0;
        for (int r = 0; r < 24; r++) begin
            for (int x = 0; x < 24; x++) begin
                if (beats >= max_beats) return;
                for (int g = 0; g < 8; g++) begin
                    if ($urandom_range(0, 99) >= gap_pct) break;
                    idle_cycle({tag, "_gap"});
                end
                @(negedge clk);
                din_valid = 1'b1;
                din       = pix_bus(kind, r, x);
                @(posedge clk);
                #1;
                beats++;
                out_exp = (r % 2 == 1) && (x % 2 == 1);
                if (out_exp) last_exp = exp_bus(kind, r / 2, x / 2);
                check_cycle(tag, {out_exp, (r == 23 && x == 23), last_exp}, r, x);
                if (dout_valid) n_out++;
                if (dout_valid && frame_last) n_last++;
            end
        end
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    task automatic check_count(string tag, int got, int expv);
        checks++;
        assert (got === expv) else begin
            failures++;
            $error("FAIL %s got %0d exp %0d", tag, got, expv);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b0;
        din       = '0;
        last_exp  = '0;
        #1;
        check_cycle("reset_state", {1'b0, 1'b0, {BW{1'b0}}}, -1, -1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle("post_reset_idle");

        send_frame("ramp", 0, 0, 576);
        check_count("ramp_outputs", n_out, 144);
        check_count("ramp_last", n_last, 1);

        send_frame("sweep", 1, 0, 576);
        check_count("sweep_outputs", n_out, 144);

        send_frame("ramp_gaps", 0, 40, 576);
        check_count("gaps_outputs", n_out, 144);
        check_count("gaps_last", n_last, 1);

        send_frame("b2b_f1", 0, 0, 576);
        check_count("b2b_f1_outputs", n_out, 144);
        check_count("b2b_f1_last", n_last, 1);
        send_frame("b2b_f2", 2, 0, 576);
        check_count("b2b_f2_outputs", n_out, 144);
        check_count("b2b_f2_last", n_last, 1);

        // Partial frame up to row 7 col 13, then reset with valid held high.
        send_frame("pre_reset", 1, 0, 7 * 24 + 13);
        @(negedge clk);
        din_valid = 1'b1;
        din       = pix_bus(0, 7, 13);
        rst_n     = 1'b0;
        #1;
        last_exp = '0;
        check_cycle("in_reset", {1'b0, 1'b0, {BW{1'b0}}}, 7, 13);
        @(posedge clk);
        #1;
        check_cycle("in_reset_edge", {1'b0, 1'b0, {BW{1'b0}}}, 7, 13);
        @(negedge clk);
        din_valid = 1'b0;
        rst_n     = 1'b1;
        send_frame("post_reset", 0, 0, 576);
        check_count("post_reset_outputs", n_out, 144);
        check_count("post_reset_last", n_last, 1);

        send_frame("iso", 3, 20, 576);
        check_count("iso_outputs", n_out, 144);
        idle_cycle("final_hold");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
